mem_request_arbiter: RTL and testbench
======================================

// Module: mem_request_arbiter
// PURPOSE
//   Shares the single byte-serial memory controller port between instruction fetch (icache miss),
//   data load and data store requesters. Owns one transaction at a time, holds the controller
//   request stable until completion, returns data/done to the owner. Drops stale fetches on flush.
// PARAMETERS
//   AGE_LIMIT  4  consecutive data grants tolerated while fetch waits (FETCH_AGE_EN only)
//   AGE_CNT_W  3  width of age counter; must hold AGE_LIMIT
// PORTS
//   clk_in        in   1   clock, all state on rising edge
//   rst_in        in   1   reset, asynchronous, active-low
//   flush_in      in   1   branch redirect; kills pending/in-flight fetch
//   if_req_in     in   1   fetch request, level, held until if_done_out or flush
//   if_addr_in    in   32  fetch address, stable while if_req_in
//   if_done_out   out  1   one-cycle pulse, if_data_out valid
//   if_data_out   out  32  fetched word
//   ld_req_in     in   1   load request, level, held until ld_done_out
//   ld_addr_in    in   32  load address
//   ld_width_in   in   3   byte count 3'b001/3'b010/3'b100
//   ld_done_out   out  1   one-cycle pulse, ld_data_out valid
//   ld_data_out   out  32  load data, zero-extended raw bytes
//   st_req_in     in   1   store request, level, held until st_done_out
//   st_addr_in    in   32  store address
//   st_width_in   in   3   byte count 3'b001/3'b010/3'b100
//   st_data_in    in   32  store data, low bytes used
//   st_done_out   out  1   one-cycle pulse, store committed
//   mc_enable_out out  1   request to memory controller, held until mc_done_in
//   mc_rw_out     out  1   1 write, 0 read
//   mc_width_out  out  3   byte count to controller
//   mc_addr_out   out  32  address to controller
//   mc_wdata_out  out  32  write data to controller
//   mc_done_in    in   1   controller completion pulse
//   mc_rdata_in   in   32  controller read data, valid with mc_done_in
// BEHAVIOUR
//   Reset (rst_in low, async): state IDLE; all *_done_out, mc_enable_out, mc_rw_out = 0;
//     data/addr/width outputs = 0; age counter = 0.
//   States: IDLE, BUSY_IF, BUSY_LD, BUSY_ST, DRAIN.
//   IDLE: sample requests; priority st > ld > if. Grant registers mc_* fields, mc_enable_out=1
//     next edge, state BUSY_x. Fetch not granted in a cycle where flush_in=1.
//   BUSY_x: mc_* outputs frozen. On edge with mc_done_in=1: mc_enable_out=0, owner done pulse
//     high for exactly one cycle, read data latched from mc_rdata_in, state IDLE.
//   Latency: req seen in IDLE at edge N -> mc_enable_out high from N; done pulse one cycle after
//     mc_done_in. One idle bubble between back-to-back transactions (re-grant from IDLE).
//   Illegal width (not 1/2/4): forwarded as 3'b100.
//   Flush: in BUSY_IF -> DRAIN (no if_done_out); DRAIN waits mc_done_in, discards data,
//     -> IDLE. In BUSY_LD/BUSY_ST flush ignored (data ops complete). Flush in DRAIN ignored.
//   Flush coincident with mc_done_in in BUSY_IF: data discarded, no if_done_out, -> IDLE.
//   Requester drops req while BUSY: transaction still completes; done pulse still issued.
//   mc_done_in while IDLE: ignored, no done pulse.
//   Store and load same cycle: store first; load granted after store done (store-to-load order).
// CONFIGURATION
//   FETCH_AGE_EN defined: age counter increments on each ld/st grant while if_req_in=1,
//     clears on fetch grant or if_req_in=0; at AGE_LIMIT next IDLE grant goes to fetch
//     regardless of data requests (unless flush_in).
//   FETCH_AGE_EN undefined: strict st > ld > if priority; no counter logic; fetch may starve.
// TESTING
//   Single fetch 0x1000, mc_done_in 3 cycles later with 0xDEADBEEF -> if_done_out 1 cycle,
//     if_data_out=0xDEADBEEF, mc_rw_out=0, mc_width_out=3'b100.
//   st_req(0x20,w=1,0xAB) + ld_req(0x20,w=1) same cycle -> store issued first, st_done_out,
//     then load with mc_addr_out=0x20; ld_done_out follows.
//   Fetch in flight, flush_in pulse -> DRAIN; mc_done_in -> no if_done_out, then new fetch
//     0x2000 granted normally.
//   Continuous ld_req with if_req held, FETCH_AGE_EN, AGE_LIMIT=4 -> fetch granted after 4th
//     load; without macro fetch never granted.
//   rst_in low mid BUSY_LD -> all outputs 0 immediately, state IDLE; after release, held
//     ld_req re-issued.
//   Illegal ld_width_in=3'b011 -> mc_width_out=3'b100; mc_done_in in IDLE -> no done pulses.

Source files
------------

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: shares one byte-serial memory controller port between fetch, load and store.
// Optional fetch anti-starvation aging is compiled in when FETCH_AGE_EN is defined.
module mem_request_arbiter #(
    parameter int AGE_LIMIT = 4,
    parameter int AGE_CNT_W = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_done_out,
    output logic [31:0] if_data_out,
    input  logic        ld_req_in,
    input  logic [31:0] ld_addr_in,
    input  logic [2:0]  ld_width_in,
    output logic        ld_done_out,
    output logic [31:0] ld_data_out,
    input  logic        st_req_in,
    input  logic [31:0] st_addr_in,
    input  logic [2:0]  st_width_in,
    input  logic [31:0] st_data_in,
    output logic        st_done_out,
    output logic        mc_enable_out,
    output logic        mc_rw_out,
    output logic [2:0]  mc_width_out,
    output logic [31:0] mc_addr_out,
    output logic [31:0] mc_wdata_out,
    input  logic        mc_done_in,
    input  logic [31:0] mc_rdata_in
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_BUSY_IF = 3'd1;
    localparam logic [2:0] S_BUSY_LD = 3'd2;
    localparam logic [2:0] S_BUSY_ST = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    // The aging counter must be able to represent the limit it saturates at.
    if (AGE_LIMIT < 1 || AGE_LIMIT >= (1 << AGE_CNT_W)) begin : g_bad_age_cfg
        $error("mem_request_arbiter: AGE_CNT_W too narrow for AGE_LIMIT");
    end

    // Widths other than 1, 2 or 4 bytes are treated as a full word.
    function automatic logic [2:0] norm_width(input logic [2:0] width);
        case (width)
            3'b001, 3'b010, 3'b100: norm_width = width;
            default:                norm_width = 3'b100;
        endcase
    endfunction

    function automatic logic [31:0] byte_mask(input logic [2:0] width);
        case (width)
            3'b001:  byte_mask = 32'h0000_00FF;
            3'b010:  byte_mask = 32'h0000_FFFF;
            default: byte_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    logic [2:0]  state_r;
    logic        if_done_r, ld_done_r, st_done_r;
    logic [31:0] if_data_r, ld_data_r;
    logic        mc_enable_r, mc_rw_r;
    logic [2:0]  mc_width_r;
    logic [31:0] mc_addr_r, mc_wdata_r;

    logic        if_ok_s, fetch_forced_s;
    logic        grant_if_s, grant_ld_s, grant_st_s;
    logic [2:0]  ld_width_s, st_width_s;

    assign if_ok_s    = if_req_in & ~flush_in;
    assign ld_width_s = norm_width(ld_width_in);
    assign st_width_s = norm_width(st_width_in);

`ifdef FETCH_AGE_EN
    logic [AGE_CNT_W-1:0] age_cnt_r;

    // Count data grants that overtook a waiting fetch; saturate at the limit.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            age_cnt_r <= '0;
        end else if (!if_req_in || grant_if_s) begin
            age_cnt_r <= '0;
        end else if ((grant_ld_s || grant_st_s) && (age_cnt_r != AGE_CNT_W'(AGE_LIMIT))) begin
            age_cnt_r <= age_cnt_r + 1'b1;
        end else begin
            age_cnt_r <= age_cnt_r;
        end
    end

    assign fetch_forced_s = if_ok_s && (age_cnt_r >= AGE_CNT_W'(AGE_LIMIT));
`else
    assign fetch_forced_s = 1'b0;
`endif

    // Grant selection in IDLE: an aged fetch wins, otherwise store > load > fetch.
    always_comb begin
        grant_if_s = 1'b0;
        grant_ld_s = 1'b0;
        grant_st_s = 1'b0;
        if (state_r == S_IDLE) begin
            if (fetch_forced_s) begin
                grant_if_s = 1'b1;
            end else if (st_req_in) begin
                grant_st_s = 1'b1;
            end else if (ld_req_in) begin
                grant_ld_s = 1'b1;
            end else if (if_ok_s) begin
                grant_if_s = 1'b1;
            end else begin
                grant_if_s = 1'b0;
            end
        end else begin
            grant_if_s = 1'b0;
        end
    end

    // Transaction FSM: launch on grant, hold controller fields, retire on mc_done_in.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r     <= S_IDLE;
            if_done_r   <= 1'b0;
            ld_done_r   <= 1'b0;
            st_done_r   <= 1'b0;
            if_data_r   <= 32'h0000_0000;
            ld_data_r   <= 32'h0000_0000;
            mc_enable_r <= 1'b0;
            mc_rw_r     <= 1'b0;
            mc_width_r  <= 3'b000;
            mc_addr_r   <= 32'h0000_0000;
            mc_wdata_r  <= 32'h0000_0000;
        end else begin
            if_done_r <= 1'b0;
            ld_done_r <= 1'b0;
            st_done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (grant_st_s) begin
                        mc_enable_r <= 1'b1;
                        mc_rw_r     <= 1'b1;
                        mc_width_r  <= st_width_s;
                        mc_addr_r   <= st_addr_in;
                        mc_wdata_r  <= st_data_in & byte_mask(st_width_s);
                        state_r     <= S_BUSY_ST;
                    end else if (grant_ld_s) begin
                        mc_enable_r <= 1'b1;
                        mc_rw_r     <= 1'b0;
                        mc_width_r  <= ld_width_s;
                        mc_addr_r   <= ld_addr_in;
                        mc_wdata_r  <= 32'h0000_0000;
                        state_r     <= S_BUSY_LD;
                    end else if (grant_if_s) begin
                        mc_enable_r <= 1'b1;
                        mc_rw_r     <= 1'b0;
                        mc_width_r  <= 3'b100;
                        mc_addr_r   <= if_addr_in;
                        mc_wdata_r  <= 32'h0000_0000;
                        state_r     <= S_BUSY_IF;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_BUSY_IF: begin
                    if (mc_done_in) begin
                        mc_enable_r <= 1'b0;
                        state_r     <= S_IDLE;
                        if (!flush_in) begin
                            if_done_r <= 1'b1;
                            if_data_r <= mc_rdata_in;
                        end else begin
                            if_done_r <= 1'b0;
                        end
                    end else if (flush_in) begin
                        state_r <= S_DRAIN;
                    end else begin
                        state_r <= S_BUSY_IF;
                    end
                end
                S_BUSY_LD: begin
                    if (mc_done_in) begin
                        mc_enable_r <= 1'b0;
                        ld_done_r   <= 1'b1;
                        ld_data_r   <= mc_rdata_in & byte_mask(mc_width_r);
                        state_r     <= S_IDLE;
                    end else begin
                        state_r <= S_BUSY_LD;
                    end
                end
                S_BUSY_ST: begin
                    if (mc_done_in) begin
                        mc_enable_r <= 1'b0;
                        st_done_r   <= 1'b1;
                        state_r     <= S_IDLE;
                    end else begin
                        state_r <= S_BUSY_ST;
                    end
                end
                S_DRAIN: begin
                    if (mc_done_in) begin
                        mc_enable_r <= 1'b0;
                        state_r     <= S_IDLE;
                    end else begin
                        state_r <= S_DRAIN;
                    end
                end
                default: begin
                    mc_enable_r <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign if_done_out   = if_done_r;
    assign if_data_out   = if_data_r;
    assign ld_done_out   = ld_done_r;
    assign ld_data_out   = ld_data_r;
    assign st_done_out   = st_done_r;
    assign mc_enable_out = mc_enable_r;
    assign mc_rw_out     = mc_rw_r;
    assign mc_width_out  = mc_width_r;
    assign mc_addr_out   = mc_addr_r;
    assign mc_wdata_out  = mc_wdata_r;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed testbench for mem_request_arbiter; expectations follow FETCH_AGE_EN when defined.
module tb_mem_request_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        flush_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_data_out;
    logic        ld_req_in;
    logic [31:0] ld_addr_in;
    logic [2:0]  ld_width_in;
    logic        ld_done_out;
    logic [31:0] ld_data_out;
    logic        st_req_in;
    logic [31:0] st_addr_in;
    logic [2:0]  st_width_in;
    logic [31:0] st_data_in;
    logic        st_done_out;
    logic        mc_enable_out;
    logic        mc_rw_out;
    logic [2:0]  mc_width_out;
    logic [31:0] mc_addr_out;
    logic [31:0] mc_wdata_out;
    logic        mc_done_in;
    logic [31:0] mc_rdata_in;

    int n_assert = 0;
    int n_fail   = 0;

    mem_request_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_data_out(if_data_out),
        .ld_req_in(ld_req_in), .ld_addr_in(ld_addr_in), .ld_width_in(ld_width_in),
        .ld_done_out(ld_done_out), .ld_data_out(ld_data_out),
        .st_req_in(st_req_in), .st_addr_in(st_addr_in), .st_width_in(st_width_in),
        .st_data_in(st_data_in), .st_done_out(st_done_out),
        .mc_enable_out(mc_enable_out), .mc_rw_out(mc_rw_out), .mc_width_out(mc_width_out),
        .mc_addr_out(mc_addr_out), .mc_wdata_out(mc_wdata_out),
        .mc_done_in(mc_done_in), .mc_rdata_in(mc_rdata_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_in = 1'b0; flush_in = 1'b0;
        if_req_in = 1'b0; if_addr_in = 32'h0;
        ld_req_in = 1'b0; ld_addr_in = 32'h0; ld_width_in = 3'b000;
        st_req_in = 1'b0; st_addr_in = 32'h0; st_width_in = 3'b000; st_data_in = 32'h0;
        mc_done_in = 1'b0; mc_rdata_in = 32'h0;
        step(); step();
        chk("rst_enable", {31'd0, mc_enable_out}, 32'd0);
        chk("rst_dones", {29'd0, if_done_out, ld_done_out, st_done_out}, 32'd0);
        chk("rst_addr", mc_addr_out, 32'd0);
        chk("rst_width_rw", {28'd0, mc_width_out, mc_rw_out}, 32'd0);
        rst_in = 1'b1;
        step();

        // single fetch
        if_req_in = 1'b1; if_addr_in = 32'h0000_1000;
        step();
        chk("if_enable", {31'd0, mc_enable_out}, 32'd1);
        chk("if_addr", mc_addr_out, 32'h0000_1000);
        chk("if_rw", {31'd0, mc_rw_out}, 32'd0);
        chk("if_width", {29'd0, mc_width_out}, 32'd4);
        step(); step();
        chk("if_hold_enable", {31'd0, mc_enable_out}, 32'd1);
        mc_done_in = 1'b1; mc_rdata_in = 32'hDEAD_BEEF;
        step();
        chk("if_done", {31'd0, if_done_out}, 32'd1);
        chk("if_data", if_data_out, 32'hDEAD_BEEF);
        chk("if_enable_off", {31'd0, mc_enable_out}, 32'd0);
        mc_done_in = 1'b0; if_req_in = 1'b0;
        step();
        chk("if_done_pulse", {31'd0, if_done_out}, 32'd0);

        // store and load together: store first
        st_req_in = 1'b1; st_addr_in = 32'h20; st_width_in = 3'b001; st_data_in = 32'h1234_56AB;
        ld_req_in = 1'b1; ld_addr_in = 32'h20; ld_width_in = 3'b001;
        step();
        chk("st_rw", {31'd0, mc_rw_out}, 32'd1);
        chk("st_addr", mc_addr_out, 32'h20);
        chk("st_width", {29'd0, mc_width_out}, 32'd1);
        chk("st_wdata", mc_wdata_out, 32'h0000_00AB);
        mc_done_in = 1'b1;
        step();
        chk("st_done", {31'd0, st_done_out}, 32'd1);
        chk("st_no_ld_done", {31'd0, ld_done_out}, 32'd0);
        chk("st_enable_off", {31'd0, mc_enable_out}, 32'd0);
        mc_done_in = 1'b0; st_req_in = 1'b0;
        step();
        chk("ld_enable", {31'd0, mc_enable_out}, 32'd1);
        chk("ld_rw", {31'd0, mc_rw_out}, 32'd0);
        chk("ld_addr", mc_addr_out, 32'h20);
        chk("st_done_pulse", {31'd0, st_done_out}, 32'd0);
        mc_done_in = 1'b1; mc_rdata_in = 32'h1234_5678;
        step();
        chk("ld_done", {31'd0, ld_done_out}, 32'd1);
        chk("ld_data", ld_data_out, 32'h0000_0078);
        mc_done_in = 1'b0; ld_req_in = 1'b0;
        step();
        chk("ld_done_pulse", {31'd0, ld_done_out}, 32'd0);

        // fetch flushed in flight, then a fresh fetch
        if_req_in = 1'b1; if_addr_in = 32'h0000_3000;
        step();
        chk("fl_enable", {31'd0, mc_enable_out}, 32'd1);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0; if_addr_in = 32'h0000_2000;
        chk("drain_enable", {31'd0, mc_enable_out}, 32'd1);
        step();
        chk("drain_addr_frozen", mc_addr_out, 32'h0000_3000);
        mc_done_in = 1'b1; mc_rdata_in = 32'h0000_0055;
        step();
        chk("drain_no_done", {31'd0, if_done_out}, 32'd0);
        chk("drain_enable_off", {31'd0, mc_enable_out}, 32'd0);
        mc_done_in = 1'b0;
        step();
        chk("refetch_addr", mc_addr_out, 32'h0000_2000);
        chk("refetch_enable", {31'd0, mc_enable_out}, 32'd1);
        mc_done_in = 1'b1; mc_rdata_in = 32'hCAFE_F00D;
        step();
        chk("refetch_data", if_data_out, 32'hCAFE_F00D);
        chk("refetch_done", {31'd0, if_done_out}, 32'd1);
        mc_done_in = 1'b0; if_req_in = 1'b0;
        step();

        // flush coincident with completion
        if_req_in = 1'b1; if_addr_in = 32'h0000_4000;
        step();
        flush_in = 1'b1; mc_done_in = 1'b1; mc_rdata_in = 32'h0000_0099;
        step();
        chk("coinc_no_done", {31'd0, if_done_out}, 32'd0);
        chk("coinc_data_kept", if_data_out, 32'hCAFE_F00D);
        chk("coinc_enable_off", {31'd0, mc_enable_out}, 32'd0);
        flush_in = 1'b0; mc_done_in = 1'b0; if_req_in = 1'b0;
        step();

        // illegal width, then async reset mid-load
        ld_req_in = 1'b1; ld_addr_in = 32'h40; ld_width_in = 3'b011;
        step();
        chk("illegal_width", {29'd0, mc_width_out}, 32'd4);
        step();
        rst_in = 1'b0;
        #1;
        chk("rst_mid_enable", {31'd0, mc_enable_out}, 32'd0);
        chk("rst_mid_addr", mc_addr_out, 32'd0);
        chk("rst_mid_width", {29'd0, mc_width_out}, 32'd0);
        step();
        rst_in = 1'b1;
        step();
        chk("reissue_enable", {31'd0, mc_enable_out}, 32'd1);
        chk("reissue_addr", mc_addr_out, 32'h40);
        mc_done_in = 1'b1; mc_rdata_in = 32'hA1B2_C3D4;
        step();
        chk("reissue_data", ld_data_out, 32'hA1B2_C3D4);
        mc_done_in = 1'b0; ld_req_in = 1'b0;
        step();

        // controller completion while idle is ignored
        mc_done_in = 1'b1;
        step();
        chk("idle_done_ign", {29'd0, if_done_out, ld_done_out, st_done_out}, 32'd0);
        step();
        chk("idle_done_ign2", {28'd0, if_done_out, ld_done_out, st_done_out, mc_enable_out}, 32'd0);
        mc_done_in = 1'b0;

        // requester drops store while busy
        st_req_in = 1'b1; st_addr_in = 32'h80; st_width_in = 3'b010; st_data_in = 32'h5555_BEEF;
        step();
        chk("drop_width", {29'd0, mc_width_out}, 32'd2);
        chk("drop_wdata", mc_wdata_out, 32'h0000_BEEF);
        st_req_in = 1'b0;
        step();
        mc_done_in = 1'b1;
        step();
        chk("drop_st_done", {31'd0, st_done_out}, 32'd1);
        mc_done_in = 1'b0;
        step();

        // fetch waiting behind a continuous load stream
        if_req_in = 1'b1; if_addr_in = 32'h0000_5000;
        ld_req_in = 1'b1; ld_addr_in = 32'h60; ld_width_in = 3'b100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("age_ld_addr", mc_addr_out, 32'h60);
            mc_done_in = 1'b1;
            step();
            chk("age_ld_done", {31'd0, ld_done_out}, 32'd1);
            mc_done_in = 1'b0;
        end
        step();
        chk("age_enable", {31'd0, mc_enable_out}, 32'd1);
`ifdef FETCH_AGE_EN
        chk("age_fetch_addr", mc_addr_out, 32'h0000_5000);
`else
        chk("age_fetch_addr", mc_addr_out, 32'h60);
`endif
        mc_done_in = 1'b1; mc_rdata_in = 32'h0BAD_F00D;
        step();
`ifdef FETCH_AGE_EN
        chk("age_if_done", {30'd0, if_done_out, ld_done_out}, 32'd2);
`else
        chk("age_if_done", {30'd0, if_done_out, ld_done_out}, 32'd1);
`endif
        mc_done_in = 1'b0; if_req_in = 1'b0; ld_req_in = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
